// File: rtl/sobel_wr_packer_if.sv
// Bus bundle between the Sobel filter, the write packer and the memory write port.
// Handshake: a word transfers on a CLK edge where OUT_VALID && OUT_READY; OUT_VALID never waits on OUT_READY.
interface sobel_wr_packer_if #(
    parameter int QDEPTH = 16
);
    localparam int LW = $clog2(QDEPTH) + 1;

    logic          FRAME_SYNC;
    logic          IN_VALID;
    logic [7:0]    IN_R;
    logic [7:0]    IN_G;
    logic [7:0]    IN_B;
    logic          OUT_VALID;
    logic          OUT_READY;
    logic [127:0]  OUT_DATA;
    logic [31:0]   OUT_ADDR;
    logic [LW-1:0] LEVEL;
    logic          OVERFLOW;
    logic          FRAME_DONE;
    logic          BUF_SEL;

    modport master (
        output FRAME_SYNC, IN_VALID, IN_R, IN_G, IN_B, OUT_READY,
        input  OUT_VALID, OUT_DATA, OUT_ADDR, LEVEL, OVERFLOW, FRAME_DONE, BUF_SEL
    );

    modport slave (
        input  FRAME_SYNC, IN_VALID, IN_R, IN_G, IN_B, OUT_READY,
        output OUT_VALID, OUT_DATA, OUT_ADDR, LEVEL, OVERFLOW, FRAME_DONE, BUF_SEL
    );
endinterface

// File: rtl/sobel_wr_packer.sv
// Packs Sobel result pixels four at a time into addressed 128-bit words and queues them for memory.
// Optional double buffering of frames is enabled with the macro SOBEL_WRPACK_DBUF_EN.
module sobel_wr_packer #(
    parameter int          IMG_W     = 1600,
    parameter int          IMG_H     = 900,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          QDEPTH    = 16
) (
    input logic              CLK,
    input logic              RST_N,
    sobel_wr_packer_if.slave bus
);
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW = $clog2(QDEPTH);
    localparam int LW = AW + 1;

    localparam logic [XW-1:0] X_LAST      = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST      = YW'(IMG_H - 1);
    localparam logic [LW-1:0] DEPTH_L     = LW'(QDEPTH);
    localparam logic [31:0]   LINE_BYTES  = 32'(IMG_W * 4);
    localparam logic [31:0]   FRAME_BYTES = 32'(IMG_W * IMG_H * 4);

    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic [95:0]    r_part;
    logic           r_ovf;
    logic           r_done;
    logic [127:0]   r_mem_data [QDEPTH];
    logic [31:0]    r_mem_addr [QDEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [LW-1:0]  r_level;

    logic           w_buf_sel;
    logic [31:0]    w_pix;
    logic [1:0]     w_slot;
    logic           w_fill;
    logic           w_last;
    logic [127:0]   w_word;
    logic [31:0]    w_addr;
    logic           w_valid;
    logic           w_pop;
    logic           w_push_ok;

    // IMG_W is a multiple of 4 and FRAME_SYNC realigns X, so the pack slot is simply X mod 4.
    assign w_pix   = {8'h00, bus.IN_R, bus.IN_G, bus.IN_B};
    assign w_slot  = r_x[1:0];
    assign w_fill  = bus.IN_VALID && !bus.FRAME_SYNC && (w_slot == 2'd3);
    assign w_last  = (r_x == X_LAST) && (r_y == Y_LAST);
    assign w_word  = {w_pix, r_part};
    assign w_addr  = BASE_ADDR
                   + (w_buf_sel ? FRAME_BYTES : 32'd0)
                   + (32'(r_y) * LINE_BYTES)
                   + ((32'(r_x) & ~32'd3) << 2);

    assign w_valid   = (r_level != '0);
    assign w_pop     = w_valid && bus.OUT_READY;
    assign w_push_ok = w_fill && ((r_level != DEPTH_L) || w_pop);

`ifdef SOBEL_WRPACK_DBUF_EN
    logic r_buf;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_buf <= 1'b0;
        end else if (w_fill && w_last) begin
            r_buf <= ~r_buf;
        end
    end

    assign w_buf_sel = r_buf;
`else
    assign w_buf_sel = 1'b0;
`endif

    // Pixel position and partial word; FRAME_SYNC takes priority over the strobe's position.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_x    <= '0;
            r_y    <= '0;
            r_part <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_fill && w_last;
            if (bus.FRAME_SYNC) begin
                r_y <= '0;
                if (bus.IN_VALID) begin
                    r_x          <= XW'(1);
                    r_part[31:0] <= w_pix;
                end else begin
                    r_x <= '0;
                end
            end else if (bus.IN_VALID) begin
                case (w_slot)
                    2'd0:    r_part[31:0]  <= w_pix;
                    2'd1:    r_part[63:32] <= w_pix;
                    2'd2:    r_part[95:64] <= w_pix;
                    default: r_part        <= r_part;
                endcase
                if (r_x == X_LAST) begin
                    r_x <= '0;
                    r_y <= (r_y == Y_LAST) ? '0 : r_y + YW'(1);
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
        end
    end

    // Word FIFO; a full queue still accepts a push when the head leaves in the same cycle.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
            r_ovf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_mem_data[r_wr_ptr] <= w_word;
                r_mem_addr[r_wr_ptr] <= w_addr;
                r_wr_ptr             <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push_ok, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
            if (w_fill && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
        end
    end

    assign bus.OUT_VALID  = w_valid;
    assign bus.OUT_DATA   = w_valid ? r_mem_data[r_rd_ptr] : '0;
    assign bus.OUT_ADDR   = w_valid ? r_mem_addr[r_rd_ptr] : '0;
    assign bus.LEVEL      = r_level;
    assign bus.OVERFLOW   = r_ovf;
    assign bus.FRAME_DONE = r_done;
    assign bus.BUF_SEL    = w_buf_sel;
endmodule

// File: tb/tb_sobel_wr_packer.sv
// Bench for sobel_wr_packer: directed scenarios plus randomized traffic against a queue-based model.
// Honours SOBEL_WRPACK_DBUF_EN the same way as the design.
module tb_sobel_wr_packer;
    localparam int          IMG_W     = 8;
    localparam int          IMG_H     = 2;
    localparam int          QDEPTH    = 4;
    localparam logic [31:0] BASE_ADDR = 32'h1000;
`ifdef SOBEL_WRPACK_DBUF_EN
    localparam bit          DBUF      = 1'b1;
`else
    localparam bit          DBUF      = 1'b0;
`endif

    logic CLK   = 1'b0;
    logic RST_N = 1'b0;
    always #5 CLK = ~CLK;

    sobel_wr_packer_if #(.QDEPTH(QDEPTH)) bus ();

    sobel_wr_packer #(
        .IMG_W    (IMG_W),
        .IMG_H    (IMG_H),
        .BASE_ADDR(BASE_ADDR),
        .QDEPTH   (QDEPTH)
    ) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model state: position, pending pixels, queue occupancy and flags.
    int           m_x = 0, m_y = 0, m_level = 0;
    bit           m_ovf = 0, m_done = 0, m_buf = 0;
    logic [31:0]  pix_q[$];
    logic [31:0]  g_addr = '0;
    logic [159:0] exp_q[$];

    bit           mon_en = 0;
    int           pop_cnt = 0, fd_cnt = 0;
    logic [31:0]  last_addr = '0;
    logic [127:0] last_data = '0;
    logic         prev_hold = 1'b0;
    logic [159:0] prev_word = '0;

    // Inputs are driven just after posedge, so at negedge they are exactly what the next edge samples.
    always @(negedge CLK) begin
        logic [159:0] e;
        logic [127:0] word;
        bit           push, pop;
        if (mon_en) begin
            check("out_valid", 160'(bus.OUT_VALID), 160'(m_level != 0));
            check("level", 160'(bus.LEVEL), 160'(m_level));
            check("overflow", 160'(bus.OVERFLOW), 160'(m_ovf));
            check("frame_done", 160'(bus.FRAME_DONE), 160'(m_done));
            check("buf_sel", 160'(bus.BUF_SEL), 160'(m_buf));
            if (prev_hold && bus.OUT_VALID)
                check("head_stable", {bus.OUT_ADDR, bus.OUT_DATA}, prev_word);
            prev_hold = bus.OUT_VALID && !bus.OUT_READY;
            prev_word = {bus.OUT_ADDR, bus.OUT_DATA};
            if (bus.FRAME_DONE) fd_cnt++;
            if (bus.OUT_VALID && bus.OUT_READY) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got %0h, expected none", {bus.OUT_ADDR, bus.OUT_DATA});
                end else begin
                    e = exp_q.pop_front();
                    check("word", {bus.OUT_ADDR, bus.OUT_DATA}, e);
                end
                last_addr = bus.OUT_ADDR;
                last_data = bus.OUT_DATA;
                pop_cnt++;
            end
        end
        if (!RST_N) begin
            m_x = 0; m_y = 0; m_level = 0;
            m_ovf = 0; m_done = 0; m_buf = 0;
            pix_q.delete();
            exp_q.delete();
            prev_hold = 1'b0;
        end else begin
            pop    = (m_level > 0) && bus.OUT_READY;
            push   = 0;
            word   = '0;
            m_done = 0;
            if (bus.FRAME_SYNC) begin
                pix_q.delete();
                m_x = 0;
                m_y = 0;
            end
            if (bus.IN_VALID) begin
                if (pix_q.size() == 0)
                    g_addr = BASE_ADDR + (m_buf ? 32'(IMG_W * IMG_H * 4) : 32'd0)
                           + 32'((m_y * IMG_W + m_x) * 4);
                pix_q.push_back({8'h00, bus.IN_R, bus.IN_G, bus.IN_B});
                if (pix_q.size() == 4) begin
                    word = {pix_q[3], pix_q[2], pix_q[1], pix_q[0]};
                    push = 1;
                    pix_q.delete();
                    if (m_x == IMG_W - 1 && m_y == IMG_H - 1) begin
                        m_done = 1;
                        if (DBUF) m_buf = !m_buf;
                    end
                end
                if (m_x == IMG_W - 1) begin
                    m_x = 0;
                    m_y = (m_y == IMG_H - 1) ? 0 : m_y + 1;
                end else begin
                    m_x = m_x + 1;
                end
            end
            if (pop) m_level--;
            if (push) begin
                if (m_level < QDEPTH) begin
                    exp_q.push_back({g_addr, word});
                    m_level++;
                end else begin
                    m_ovf = 1;
                end
            end
        end
    end

    task automatic drive(input bit v, input bit s, input logic [7:0] r, input logic [7:0] g,
                         input logic [7:0] b);
        bus.IN_VALID   = v;
        bus.FRAME_SYNC = s;
        bus.IN_R       = r;
        bus.IN_G       = g;
        bus.IN_B       = b;
        @(posedge CLK);
        #1;
        bus.IN_VALID   = 1'b0;
        bus.FRAME_SYNC = 1'b0;
    endtask

    task automatic pix(input logic [7:0] v);
        drive(1'b1, 1'b0, v, v, v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic drain();
        int n = 0;
        bus.OUT_READY = 1'b1;
        while (m_level != 0 && n < 100) begin
            @(posedge CLK);
            #1;
            n++;
        end
        check("drain_level", 160'(bus.LEVEL), 160'(0));
        check("drain_pending", 160'(exp_q.size()), 160'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0, f0, pct;
        bus.IN_VALID = 0; bus.FRAME_SYNC = 0; bus.OUT_READY = 0;
        bus.IN_R = 0; bus.IN_G = 0; bus.IN_B = 0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N  = 1'b1;
        mon_en = 1'b1;
        check("reset_out_data", 160'(bus.OUT_DATA), 160'(0));
        check("reset_out_addr", 160'(bus.OUT_ADDR), 160'(0));
        check("reset_valid", 160'(bus.OUT_VALID), 160'(0));

        // First words of a frame and the 1-cycle push latency.
        bus.OUT_READY = 1'b1;
        f0 = fd_cnt;
        for (int i = 0; i < 3; i++) pix(8'(i));
        check("valid_before_4th", 160'(bus.OUT_VALID), 160'(0));
        pix(8'd3);
        check("valid_after_4th", 160'(bus.OUT_VALID), 160'(1));
        check("first_addr", 160'(bus.OUT_ADDR), 160'(32'h1000));
        check("first_data", 160'(bus.OUT_DATA),
              160'({32'h00030303, 32'h00020202, 32'h00010101, 32'h00000000}));
        for (int i = 4; i < 8; i++) pix(8'(i));
        idle(2);
        check("second_addr", 160'(last_addr), 160'(32'h1010));
        for (int i = 8; i < 16; i++) pix(8'(i));
        idle(2);
        check("frame_end_addr", 160'(last_addr), 160'(32'h1030));
        check("frame_done_count", 160'(fd_cnt - f0), 160'(1));
        for (int i = 0; i < 4; i++) pix(8'($urandom_range(0, 255)));
        idle(2);
        check("next_frame_addr", 160'(last_addr), 160'(DBUF ? 32'h1040 : 32'h1000));

        // Overflow: 24 strobes into a stalled queue drop two words.
        do_reset();
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 24; i++) pix(8'($urandom_range(0, 255)));
        check("ovf_level", 160'(bus.LEVEL), 160'(4));
        check("ovf_flag", 160'(bus.OVERFLOW), 160'(1));
        p0 = pop_cnt;
        drain();
        check("ovf_kept_words", 160'(pop_cnt - p0), 160'(4));
        check("ovf_last_addr", 160'(last_addr), 160'(32'h1030));
        for (int i = 0; i < 8; i++) pix(8'($urandom_range(0, 255)));
        idle(3);
        check("post_ovf_addr", 160'(last_addr), 160'(DBUF ? 32'h1070 : 32'h1030));

        // Full queue: pop and push on the same edge.
        do_reset();
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 16; i++) pix(8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) pix(8'($urandom_range(0, 255)));
        check("full_level", 160'(bus.LEVEL), 160'(4));
        p0 = pop_cnt;
        bus.OUT_READY = 1'b1;
        pix(8'hA5);
        bus.OUT_READY = 1'b0;
        check("pushpop_level", 160'(bus.LEVEL), 160'(4));
        check("pushpop_ovf", 160'(bus.OVERFLOW), 160'(0));
        check("pushpop_pops", 160'(pop_cnt - p0), 160'(1));
        drain();

        // FRAME_SYNC together with a strobe restarts at slot 0 of (0,0).
        do_reset();
        bus.OUT_READY = 1'b1;
        pix(8'h11);
        pix(8'h22);
        drive(1'b1, 1'b1, 8'h55, 8'h55, 8'h55);
        for (int i = 0; i < 3; i++) pix(8'($urandom_range(0, 255)));
        idle(2);
        check("sync_addr", 160'(last_addr), 160'(32'h1000));
        check("sync_slot0", 160'(last_data[31:0]), 160'(32'h00555555));

        // Reset mid-frame with queued words.
        do_reset();
        bus.OUT_READY = 1'b0;
        for (int i = 0; i < 14; i++) pix(8'($urandom_range(0, 255)));
        check("queued_level", 160'(bus.LEVEL), 160'(3));
        do_reset();
        check("midrst_valid", 160'(bus.OUT_VALID), 160'(0));
        check("midrst_level", 160'(bus.LEVEL), 160'(0));
        check("midrst_ovf", 160'(bus.OVERFLOW), 160'(0));
        check("midrst_buf", 160'(bus.BUF_SEL), 160'(0));
        bus.OUT_READY = 1'b1;
        p0 = pop_cnt;
        for (int i = 0; i < 4; i++) pix(8'($urandom_range(0, 255)));
        idle(2);
        check("midrst_pops", 160'(pop_cnt - p0), 160'(1));
        check("midrst_addr", 160'(last_addr), 160'(32'h1000));

        // Randomized traffic with varying drain pressure.
        do_reset();
        for (int ph = 0; ph < 4; ph++) begin
            pct = (ph == 0) ? 95 : (ph == 1) ? 50 : (ph == 2) ? 15 : 80;
            for (int c = 0; c < 250; c++) begin
                bus.OUT_READY = ($urandom_range(0, 99) < pct);
                drive($urandom_range(0, 3) != 0, $urandom_range(0, 79) == 0,
                      8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                      8'($urandom_range(0, 255)));
            end
        end
        drain();
        idle(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/sobel_wr_packer.md
Name: sobel_wr_packer

Overview:
- Downstream neighbour of the Sobel filter stage.
- Consumes the filter's write strobe and 8-bit R/G/B result pixels, one pixel per strobe.
- Packs four pixels into 128-bit words, generates the raster-order byte address of each word, and buffers words in a small FIFO.
- Drains the FIFO to the memory write port through a valid/ready handshake. The filter cannot stall, so overflow drops words and is flagged.

Parameters:
- IMG_W, 1600, pixels per line; must be a multiple of 4.
- IMG_H, 900, lines per frame.
- BASE_ADDR, 32'h0000_0000, byte address of pixel (0,0) of buffer 0.
- QDEPTH, 16, word FIFO depth; power of two, minimum 2.

Ports:
- CLK  in  1  clock.
- RST_N  in  1  synchronous reset, active-low.
- FRAME_SYNC  in  1  one-cycle pulse; restarts pixel position at (0,0).
- IN_VALID  in  1  pixel strobe; connect to the filter's WREN.
- IN_R  in  8  red channel of the pixel.
- IN_G  in  8  green channel of the pixel.
- IN_B  in  8  blue channel of the pixel.
- OUT_VALID  out  1  FIFO head word is valid.
- OUT_READY  in  1  memory port accepts the head word.
- OUT_DATA  out  128  packed word at the FIFO head.
- OUT_ADDR  out  32  byte address of OUT_DATA.
- LEVEL  out  $clog2(QDEPTH)+1  current FIFO occupancy.
- OVERFLOW  out  1  sticky; a word was dropped.
- FRAME_DONE  out  1  one-cycle pulse; last word of the frame has been generated.
- BUF_SEL  out  1  buffer index of the frame currently being written.

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - Clears the pixel counters X and Y, the pack index, the partial word and the FIFO.
  - All outputs read 0, including OUT_DATA and OUT_ADDR.
  - Reset mid-frame discards all queued and partial data.
- Pixel format: {8'h00,R,G,B}. Pack slot k (0..3) occupies bits [32k+31:32k]; the first pixel of a group goes to slot 0.
- Counters:
  - Each IN_VALID cycle increments X.
  - At X=IMG_W-1, X returns to 0 and Y increments.
  - At (IMG_W-1, IMG_H-1), X and Y return to (0,0).
- Word address: BASE_ADDR + BUF_SEL*IMG_W*IMG_H*4 + (Y*IMG_W + Xg)*4, where Xg is the X of slot 0. Address arithmetic is 32-bit and wraps modulo 2^32.
- Word completion and push:
  - On the IN_VALID that fills slot 3, the completed word and its address are pushed to the FIFO in the same edge.
  - OUT_VALID rises the next cycle if the FIFO was empty, i.e. latency is 1 cycle from the 4th pixel to OUT_VALID.
- FIFO:
  - Pop occurs when OUT_VALID && OUT_READY.
  - A push is accepted if LEVEL<QDEPTH, or if LEVEL==QDEPTH and a pop occurs in the same cycle.
  - Simultaneous push and pop leaves LEVEL unchanged.
  - A rejected push drops the word and sets OVERFLOW; only reset clears OVERFLOW.
  - Counters and addresses keep advancing after a drop, so later words still carry correct addresses.
  - OUT_DATA and OUT_ADDR are stable while OUT_VALID && !OUT_READY.
- FRAME_DONE: pulses on the cycle after the push attempt of the word containing pixel (IMG_W-1, IMG_H-1). It pulses even if that word was dropped.
- FRAME_SYNC:
  - Forces X, Y and the pack index to 0 and discards any partial word.
  - Queued words are kept.
  - If IN_VALID occurs in the same cycle, FRAME_SYNC wins for the position: that pixel is written to slot 0 at (0,0), and the next position is X=1.
  - FRAME_SYNC does not pulse FRAME_DONE and does not toggle BUF_SEL.
- Input pacing: IN_VALID can be asserted every cycle with no stall path. The sustained drain rate must be at least 1 word per 4 pixel strobes.

Optional Feature:
- Macro SOBEL_WRPACK_DBUF_EN.
- Defined: BUF_SEL toggles on the cycle FRAME_DONE pulses, so successive frames alternate between buffer 0 and buffer 1 (buffer 1 at offset IMG_W*IMG_H*4). Reset sets BUF_SEL=0.
- Undefined: BUF_SEL is tied to 0 and all frames are written to BASE_ADDR.

Test Plan:
- Setup: IMG_W=8, IMG_H=2, BASE_ADDR=32'h1000, QDEPTH=4.
- 8 strobes with R=G=B=i (i=0..7), OUT_READY=1 -> 2 words:
  - addr 0x1000, data {32'h00030303,32'h00020202,32'h00010101,32'h00000000};
  - addr 0x1010;
  - OUT_VALID rises 1 cycle after the 4th strobe.
- Full frame of 16 strobes -> words at 0x1000, 0x1010, 0x1020, 0x1030; FRAME_DONE pulses once; the next strobe maps to 0x1000 with the macro off and to 0x1040 with it on.
- OUT_READY=0, 24 strobes -> LEVEL saturates at 4, OVERFLOW=1, 2 words dropped; releasing OUT_READY yields addresses 0x1000..0x1030 in order, and the next frame's word address is correct.
- LEVEL=4, pop and push in the same cycle -> push accepted, LEVEL stays 4, OVERFLOW stays 0.
- 2 strobes, then FRAME_SYNC together with a strobe of value 0x55 -> the partial word is discarded, the next word's address is 0x1000, and slot 0 holds 32'h00555555.
- RST_N low for 1 cycle mid-frame with 3 words queued -> OUT_VALID=0, LEVEL=0, OVERFLOW=0 and BUF_SEL=0 on the next cycle; the next strobe maps to 0x1000.
